// File: rtl/slow_ch_rx_dma.sv
// slow_ch_rx_dma: input-channel DMA for one slow channel receiver.
// Moves 64-bit receiver words into central memory at CA, stepping CA until it
// reaches CL or the sender disconnects, then raises a level interrupt.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_rx_full/data    receiver word available / word
//   o_rx_rd           one-cycle pop of the receiver word (combinational)
//   i_rx_int          disconnect indication from the receiver
//   i_cl_wr/i_ca_wr   CPU loads of CL / CA (CA load arms the channel)
//   i_wdata           CPU write data
//   i_clear           abort transfer, drop interrupt
//   i_int_clr         interrupt acknowledge
//   o_ca              current address readback
//   o_busy            channel armed
//   o_int, o_disc     interrupt level, interrupt caused by disconnect
//   o_mem_req/addr/data, i_mem_ack   memory write port
module slow_ch_rx_dma #(
  parameter int unsigned AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rx_full,
  input  logic [63:0]   i_rx_data,
  output logic          o_rx_rd,
  input  logic          i_rx_int,
  input  logic          i_cl_wr,
  input  logic          i_ca_wr,
  input  logic [AW-1:0] i_wdata,
  input  logic          i_clear,
  input  logic          i_int_clr,
  output logic [AW-1:0] o_ca,
  output logic          o_busy,
  output logic          o_int,
  output logic          o_disc,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic [63:0]   o_mem_data,
  input  logic          i_mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, MREQ, DONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] ca, ca_n, cl, cl_n, addr_n, ca_inc;
  logic [63:0]   data_n;
  logic          disc_flag, disc_flag_n, disc_n;

  assign ca_inc = ca + AW'(1);
  assign o_ca   = ca;

  // Next-state, register updates and the receiver pop strobe.
  always_comb begin
    state_n     = state;
    ca_n        = ca;
    cl_n        = cl;
    addr_n      = o_mem_addr;
    data_n      = o_mem_data;
    disc_n      = o_disc;
    disc_flag_n = disc_flag | (i_rx_int && (state == WAIT || state == MREQ));
    o_rx_rd     = 1'b0;

    // CL must not move under an in-flight limit compare.
    if (i_cl_wr && state != MREQ) cl_n = i_wdata;

    case (state)
      IDLE: begin
        if (i_ca_wr) begin
          ca_n        = i_wdata;
          disc_flag_n = 1'b0;
          disc_n      = 1'b0;
          state_n     = (i_wdata == cl) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // A held word is always drained before a disconnect completes.
        if (i_rx_full) begin
          addr_n  = ca;
          data_n  = i_rx_data;
          state_n = MREQ;
        end else if (disc_flag) begin
          disc_n  = 1'b1;
          state_n = DONE;
        end
      end
      MREQ: begin
        if (i_mem_ack) begin
          o_rx_rd = 1'b1;
          ca_n    = ca_inc;
          if (ca_inc == cl) begin
            disc_n  = 1'b0;
            state_n = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      DONE: begin
        if (i_int_clr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Clear wins: a coincident ack is neither counted nor popped.
    if (i_clear) begin
      state_n     = IDLE;
      ca_n        = ca;
      disc_flag_n = 1'b0;
      o_rx_rd     = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ca         <= '0;
      cl         <= '0;
      disc_flag  <= 1'b0;
      o_disc     <= 1'b0;
      o_busy     <= 1'b0;
      o_int      <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      state      <= state_n;
      ca         <= ca_n;
      cl         <= cl_n;
      disc_flag  <= disc_flag_n;
      o_disc     <= disc_n;
      o_busy     <= (state_n == WAIT) || (state_n == MREQ);
      o_int      <= (state_n == DONE);
      o_mem_req  <= (state_n == MREQ);
      o_mem_addr <= addr_n;
      o_mem_data <= data_n;
    end
  end

endmodule

// File: tb/tb_slow_ch_rx_dma.sv
// Scoreboard bench for slow_ch_rx_dma: directed tests push expected memory
// writes; a negedge monitor pops and compares on every accepted write.
module tb_slow_ch_rx_dma;
  localparam int unsigned AW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_rx_full = 1'b0;
  logic [63:0]   i_rx_data = '0;
  logic          o_rx_rd;
  logic          i_rx_int = 1'b0;
  logic          i_cl_wr = 1'b0;
  logic          i_ca_wr = 1'b0;
  logic [AW-1:0] i_wdata = '0;
  logic          i_clear = 1'b0;
  logic          i_int_clr = 1'b0;
  logic [AW-1:0] o_ca;
  logic          o_busy, o_int, o_disc, o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [63:0]   o_mem_data;
  logic          i_mem_ack = 1'b0;

  slow_ch_rx_dma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .i_rx_full(i_rx_full), .i_rx_data(i_rx_data),
    .o_rx_rd(o_rx_rd), .i_rx_int(i_rx_int), .i_cl_wr(i_cl_wr), .i_ca_wr(i_ca_wr),
    .i_wdata(i_wdata), .i_clear(i_clear), .i_int_clr(i_int_clr), .o_ca(o_ca),
    .o_busy(o_busy), .o_int(o_int), .o_disc(o_disc), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .i_mem_ack(i_mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] rxq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_ack_cyc = 0;
  int          rd_cnt = 0;
  int          req_cnt = 0;
  int          ack_wait = 0;
  bit          ack_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: holds words until popped by o_rx_rd.
  always @(negedge clk) begin
    if (o_rx_rd && !rst) begin
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    i_rx_full = (rxq.size() > 0);
    i_rx_data = (rxq.size() > 0) ? rxq[0] : 64'h0;
  end

  // Arbiter model: ack after ack_wait stall cycles.
  int wcnt = 0;
  initial forever begin
    @(posedge clk); #1;
    if (i_mem_ack) begin
      i_mem_ack = 1'b0;
      wcnt = 0;
    end else if (o_mem_req && ack_en) begin
      if (wcnt == ack_wait) i_mem_ack = 1'b1;
      else wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: scoreboard compare, request stability, pop strobe.
  logic          req_prev = 1'b0, ack_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  logic [63:0]   data_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_req && i_mem_ack && !i_clear) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", o_mem_addr, o_mem_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(o_mem_addr), 64'(e.addr));
          check("wr_data", o_mem_data, e.data);
        end
        last_ack_cyc = cyc;
      end
      if (o_mem_req && req_prev && !ack_prev) begin
        check("req_stable_addr", 64'(o_mem_addr), 64'(addr_prev));
        check("req_stable_data", o_mem_data, data_prev);
      end
      if (o_rx_rd || o_mem_req)
        check("rx_rd_in_ack_cycle", 64'(o_rx_rd), 64'(o_mem_req && i_mem_ack && !i_clear));
      if (o_rx_rd) rd_cnt++;
      if (o_mem_req) req_cnt++;
      req_prev  = o_mem_req;
      ack_prev  = i_mem_ack;
      addr_prev = o_mem_addr;
      data_prev = o_mem_data;
    end
  end

  task automatic arm(input logic [AW-1:0] cl, input logic [AW-1:0] ca);
    @(posedge clk); #1; i_cl_wr = 1'b1; i_wdata = cl;
    @(posedge clk); #1; i_cl_wr = 1'b0; i_ca_wr = 1'b1; i_wdata = ca;
    @(posedge clk); #1; i_ca_wr = 1'b0;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [63:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    rxq.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic wait_int(input int bound, output int rise_cyc);
    rise_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_int) begin rise_cyc = cyc; break; end
    end
    if (rise_cyc < 0) begin
      checks++; failures++;
      $display("FAIL int_timeout: got o_int 0 expected 1 within %0d cycles", bound);
    end
  endtask

  task automatic pulse_int_clr(input bit use_clear);
    @(posedge clk); #1;
    if (use_clear) i_clear = 1'b1; else i_int_clr = 1'b1;
    @(posedge clk); #1; i_clear = 1'b0; i_int_clr = 1'b0;
    @(negedge clk);
    check("int_dropped", 64'(o_int), 64'h0);
  endtask

  initial begin
    int rc, rd0, req0;
    logic [63:0] w;
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, rd0, req0;
    logic [63:0] w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ca", 64'(o_ca), 64'h0);
    check("rst_busy", 64'(o_busy), 64'h0);
    check("rst_int", 64'(o_int), 64'h0);
    check("rst_disc", 64'(o_disc), 64'h0);
    check("rst_req", 64'(o_mem_req), 64'h0);
    check("rst_addr", 64'(o_mem_addr), 64'h0);
    check("rst_data", o_mem_data, 64'h0);
    check("rst_rd", 64'(o_rx_rd), 64'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Test 1: four words to 0x0C..0x0F, limit at 0x10.
    rd0 = rd_cnt;
    for (int i = 0; i < 4; i++)
      push_word(AW'(32'h0C + i), 64'h1111_2222_3333_4400 | 64'(i));
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_pop", 64'(rd_cnt - rd0), 64'h0);
    arm(22'h000010, 22'h00000C);
    @(negedge clk);
    check("busy_after_arm", 64'(o_busy), 64'h1);
    wait_int(40, rc);
    check("t1_int_latency", 64'(rc - last_ack_cyc), 64'h1);
    check("t1_disc", 64'(o_disc), 64'h0);
    check("t1_ca", 64'(o_ca), 64'h10);
    check("t1_rd_count", 64'(rd_cnt - rd0), 64'h4);
    pulse_int_clr(1'b0);

    // Test 2: three words then disconnect.
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++)
      push_word(AW'(32'h100 + i), 64'hDEAD_BEEF_0000_0000 | 64'(i));
    arm(22'h000200, 22'h000100);
    i_rx_int = 1'b1;
    @(posedge clk); #1; i_rx_int = 1'b0;
    wait_int(40, rc);
    check("t2_disc", 64'(o_disc), 64'h1);
    check("t2_ca", 64'(o_ca), 64'h103);
    check("t2_rd_count", 64'(rd_cnt - rd0), 64'h3);
    pulse_int_clr(1'b1);
    check("t2_disc_holds", 64'(o_disc), 64'h1);

    // Test 3: CA == CL arms straight into DONE.
    rd0 = rd_cnt; req0 = req_cnt;
    arm(22'h000055, 22'h000055);
    wait_int(2, rc);
    check("t3_disc", 64'(o_disc), 64'h0);
    check("t3_no_req", 64'(req_cnt - req0), 64'h0);
    check("t3_no_rd", 64'(rd_cnt - rd0), 64'h0);
    check("t3_ca", 64'(o_ca), 64'h55);
    pulse_int_clr(1'b0);

    // Test 4: five stall cycles before the ack.
    rd0 = rd_cnt; req0 = req_cnt;
    ack_wait = 5;
    push_word(22'h000020, 64'hCAFE_F00D_1234_5678);
    arm(22'h000021, 22'h000020);
    wait_int(40, rc);
    check("t4_req_cycles", 64'(req_cnt - req0), 64'h6);
    check("t4_rd_single", 64'(rd_cnt - rd0), 64'h1);
    check("t4_ca", 64'(o_ca), 64'h21);
    ack_wait = 0;
    pulse_int_clr(1'b0);

    // Test 5: CA wraps from the top of the address space.
    push_word(22'h3FFFFF, 64'hAAAA_0000_0000_0001);
    push_word(22'h000000, 64'hAAAA_0000_0000_0002);
    arm(22'h000001, 22'h3FFFFF);
    wait_int(40, rc);
    check("t5_ca", 64'(o_ca), 64'h1);
    check("t5_disc", 64'(o_disc), 64'h0);
    pulse_int_clr(1'b0);

    // Test 6: clear withdraws an un-acked request.
    rd0 = rd_cnt;
    ack_en = 1'b0;
    w = 64'h5A5A_A5A5_0F0F_F0F0;
    rxq.push_back(w);
    arm(22'h000040, 22'h000030);
    rc = 0;
    for (int i = 0; i < 20 && !o_mem_req; i++) begin @(negedge clk); rc = i; end
    check("t6_req_seen", 64'(o_mem_req), 64'h1);
    repeat (2) @(posedge clk);
    #1; i_clear = 1'b1;
    @(posedge clk); #1; i_clear = 1'b0;
    @(negedge clk);
    check("t6_req_dropped", 64'(o_mem_req), 64'h0);
    check("t6_idle", 64'(o_busy), 64'h0);
    check("t6_ca_kept", 64'(o_ca), 64'h30);
    check("t6_no_pop", 64'(rd_cnt - rd0), 64'h0);
    check("t6_word_kept", 64'(rxq.size()), 64'h1);
    ack_en = 1'b1;
    begin
      wr_t e;
      e.addr = 22'h00003F; e.data = w;
      exp_q.push_back(e);
    end
    arm(22'h000040, 22'h00003F);
    wait_int(40, rc);
    check("t6_rearm_ca", 64'(o_ca), 64'h40);
    check("t6_rearm_rd", 64'(rd_cnt - rd0), 64'h1);
    pulse_int_clr(1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
